// File: rtl/ue14500_sequencer.sv
// Program sequencer for the UE14500 1-bit core: writable program store, program
// counter and 2-deep return stack, issuing each instruction as a FETCH/EXEC pair.
module ue14500_sequencer #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [7:0]        prog_data,
    output logic [3:0]        instr,
    output logic [3:0]        operand,
    output logic              instr_valid,
    output logic              phase,
    input  logic              jmp_flag,
    input  logic              rtn_flag,
    input  logic              flagf_flag,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              stack_err,
    output logic [1:0]        dbg_state
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t            state, state_n;
    logic [7:0]        mem [0:DEPTH-1];
    logic [ADDR_W-1:0] pc_n, pc_inc;
    logic [ADDR_W-1:0] stk0, stk1, stk0_n, stk1_n;
    logic [1:0]        depth, depth_n;
    logic              err_n;
    logic              fetch;

    assign pc_inc    = pc + ADDR_W'(1);
    assign dbg_state = state;

    // stk1 is the top of stack when depth is 2, stk0 when depth is 1.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        depth_n = depth;
        stk0_n  = stk0;
        stk1_n  = stk1;
        err_n   = stack_err;
        fetch   = 1'b0;
        case (state)
            S_IDLE: begin
                if (run) begin
                    state_n = S_FETCH;
                    fetch   = 1'b1;
                end
            end
            S_FETCH: state_n = S_EXEC;
            S_EXEC: begin
                if (flagf_flag) begin
                    pc_n    = pc_inc;
                    state_n = S_HALT;
                end else begin
                    if (jmp_flag) begin
                        pc_n = ADDR_W'(operand);
                        if (depth == 2'd2) begin
                            stk0_n = stk1;
                            stk1_n = pc_inc;
                            err_n  = 1'b1;
                        end else if (depth == 2'd1) begin
                            stk1_n  = pc_inc;
                            depth_n = 2'd2;
                        end else begin
                            stk0_n  = pc_inc;
                            depth_n = 2'd1;
                        end
                    end else if (rtn_flag) begin
                        if (depth == 2'd2) begin
                            pc_n    = stk1;
                            depth_n = 2'd1;
                        end else if (depth == 2'd1) begin
                            pc_n    = stk0;
                            depth_n = 2'd0;
                        end else begin
                            pc_n  = '0;
                            err_n = 1'b1;
                        end
                    end else begin
                        pc_n = pc_inc;
                    end
                    if (run) begin
                        state_n = S_FETCH;
                        fetch   = 1'b1;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            S_HALT: begin
                if (!run) begin
                    state_n = S_IDLE;
                    pc_n    = '0;
                    depth_n = 2'd0;
                    err_n   = 1'b0;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // instr_valid marks a live instruction; phase 0 is FETCH, phase 1 is EXEC,
    // and the core's flags are only taken on the edge closing the EXEC cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pc          <= '0;
            depth       <= 2'd0;
            stk0        <= '0;
            stk1        <= '0;
            stack_err   <= 1'b0;
            instr       <= 4'h0;
            operand     <= 4'h0;
            instr_valid <= 1'b0;
            phase       <= 1'b0;
            halted      <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            depth       <= depth_n;
            stk0        <= stk0_n;
            stk1        <= stk1_n;
            stack_err   <= err_n;
            instr_valid <= (state_n == S_FETCH) || (state_n == S_EXEC);
            phase       <= (state_n == S_EXEC);
            halted      <= (state_n == S_HALT);
            if (fetch) begin
                {instr, operand} <= mem[pc_n];
            end else if ((state_n == S_IDLE) || (state_n == S_HALT)) begin
                instr   <= 4'h0;
                operand <= 4'h0;
            end
        end
    end

    // Store is left unreset; a same-edge fetch of the written address sees the old word.
    always_ff @(posedge clk) begin
        if (prog_we && ((state == S_IDLE) || (state == S_HALT))) begin
            mem[prog_addr] <= prog_data;
        end
    end

endmodule

// File: tb/tb_ue14500_sequencer.sv
// Bench for ue14500_sequencer: instruction-level reference model checked every
// cycle, plus directed program scenarios with hand-computed expectations.
module tb_ue14500_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       prog_we = 1'b0;
  logic [3:0] prog_addr = 4'h0;
  logic [7:0] prog_data = 8'h00;
  logic [3:0] instr, operand;
  logic       instr_valid, phase;
  logic       jmp_flag = 1'b0, rtn_flag = 1'b0, flagf_flag = 1'b0;
  logic [3:0] pc;
  logic       halted, stack_err;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_fail = 0;

  ue14500_sequencer #(.ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .instr(instr),
    .operand(operand), .instr_valid(instr_valid), .phase(phase),
    .jmp_flag(jmp_flag), .rtn_flag(rtn_flag), .flagf_flag(flagf_flag),
    .pc(pc), .halted(halted), .stack_err(stack_err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  localparam int M_IDLE = 0, M_FETCH = 1, M_EXEC = 2, M_HALT = 3;
  int         m_mode = M_IDLE;
  logic [3:0] m_pc = 4'h0;
  logic       m_err = 1'b0;
  logic [7:0] m_cur = 8'h00;
  logic [7:0] m_mem [16];
  logic [3:0] m_stk [$];
  logic       m_wr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = M_IDLE;
      m_pc   = 4'h0;
      m_err  = 1'b0;
      m_cur  = 8'h00;
      m_stk.delete();
    end else begin
      m_wr = prog_we && (m_mode == M_IDLE || m_mode == M_HALT);
      case (m_mode)
        M_IDLE: if (run) begin m_cur = m_mem[m_pc]; m_mode = M_FETCH; end
        M_FETCH: m_mode = M_EXEC;
        M_EXEC: begin
          if (flagf_flag) begin
            m_pc = 4'(m_pc + 4'd1);
            m_mode = M_HALT;
          end else begin
            if (jmp_flag) begin
              if (m_stk.size() == 2) begin
                void'(m_stk.pop_front());
                m_err = 1'b1;
              end
              m_stk.push_back(4'(m_pc + 4'd1));
              m_pc = m_cur[3:0];
            end else if (rtn_flag) begin
              if (m_stk.size() == 0) begin
                m_pc = 4'h0;
                m_err = 1'b1;
              end else begin
                m_pc = m_stk.pop_back();
              end
            end else begin
              m_pc = 4'(m_pc + 4'd1);
            end
            if (run) begin m_cur = m_mem[m_pc]; m_mode = M_FETCH; end
            else m_mode = M_IDLE;
          end
        end
        default: begin
          if (!run) begin
            m_mode = M_IDLE;
            m_pc = 4'h0;
            m_err = 1'b0;
            m_stk.delete();
          end
        end
      endcase
      if (m_wr) m_mem[prog_addr] = prog_data;
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // every-cycle comparison against the model
  logic exp_valid;
  always @(negedge clk) begin
    if (rst_n) begin
      exp_valid = (m_mode == M_FETCH) || (m_mode == M_EXEC);
      check("cyc_valid", {7'd0, instr_valid}, {7'd0, exp_valid});
      check("cyc_phase", {7'd0, phase}, {7'd0, m_mode == M_EXEC});
      check("cyc_halted", {7'd0, halted}, {7'd0, m_mode == M_HALT});
      check("cyc_instr", {4'd0, instr}, {4'd0, exp_valid ? m_cur[7:4] : 4'h0});
      check("cyc_operand", {4'd0, operand}, {4'd0, exp_valid ? m_cur[3:0] : 4'h0});
      check("cyc_pc", {4'd0, pc}, {4'd0, m_pc});
      check("cyc_stack_err", {7'd0, stack_err}, {7'd0, m_err});
    end
  end

  // ---------------- driver tasks ----------------
  logic [7:0] prog [16];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_prog();
    for (int i = 0; i < 16; i++) begin
      prog_we = 1'b1;
      prog_addr = 4'(i);
      prog_data = prog[i];
      step(1);
    end
    prog_we = 1'b0;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) prog[i] = 8'h00;
  endtask

  task automatic wait_exec(input logic [3:0] at);
    int n = 0;
    while (!(m_mode == M_EXEC && m_pc == at) && n < 200) begin
      step(1);
      n++;
    end
    if (n >= 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_exec_%0h: timeout got mode %0d expected EXEC", at, m_mode);
    end
  endtask

  task automatic to_idle();
    int n = 0;
    run = 1'b0;
    while (m_mode != M_IDLE && n < 50) begin
      step(1);
      n++;
    end
    if (n >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL to_idle: timeout got mode %0d expected IDLE", m_mode);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [3:0] seq [6];

  initial begin
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    #12;
    check("rst_pc", {4'd0, pc}, 8'h00);
    check("rst_valid", {7'd0, instr_valid}, 8'h00);
    check("rst_halted", {7'd0, halted}, 8'h00);
    check("rst_stack_err", {7'd0, stack_err}, 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1);

    // linear program
    clear_prog();
    prog[0] = 8'h41; prog[1] = 8'h80; prog[2] = 8'h00;
    load_prog();
    run = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (i == 4) run = 1'b0;
      @(negedge clk);
      seq[i] = instr;
    end
    check("lin_i0", {4'd0, seq[0]}, 8'h04);
    check("lin_i1", {4'd0, seq[1]}, 8'h04);
    check("lin_i2", {4'd0, seq[2]}, 8'h08);
    check("lin_i3", {4'd0, seq[3]}, 8'h08);
    check("lin_i4", {4'd0, seq[4]}, 8'h00);
    check("lin_i5", {4'd0, seq[5]}, 8'h00);
    step(1);
    check("lin_pc_end", {4'd0, pc}, 8'h03);
    check("lin_idle", {7'd0, instr_valid}, 8'h00);

    // jump / return / halt / restart
    clear_prog();
    prog[0] = 8'h41; prog[1] = 8'hC6; prog[2] = 8'h80;
    prog[6] = 8'h41; prog[7] = 8'hE0;
    load_prog();
    run = 1'b1;
    wait_exec(4'h1);
    jmp_flag = 1'b1; step(1); jmp_flag = 1'b0;
    check("jmp_pc", {4'd0, pc}, 8'h06);
    wait_exec(4'h7);
    rtn_flag = 1'b1; step(1); rtn_flag = 1'b0;
    check("rtn_pc", {4'd0, pc}, 8'h02);
    check("rtn_err", {7'd0, stack_err}, 8'h00);
    jmp_flag = 1'b1; step(1); jmp_flag = 1'b0;   // FETCH-only flag is ignored
    step(1);
    check("fetch_flag_pc", {4'd0, pc}, 8'h03);
    wait_exec(4'h3);
    flagf_flag = 1'b1; step(1); flagf_flag = 1'b0;
    check("halt_halted", {7'd0, halted}, 8'h01);
    check("halt_valid", {7'd0, instr_valid}, 8'h00);
    step(3);
    check("halt_held", {7'd0, halted}, 8'h01);
    run = 1'b0; step(1);
    check("halt_idle_pc", {4'd0, pc}, 8'h00);
    check("halt_idle_halted", {7'd0, halted}, 8'h00);
    run = 1'b1; step(1);
    check("restart_instr", {4'd0, instr}, 8'h04);
    check("restart_phase", {7'd0, phase}, 8'h00);
    to_idle();

    // stack errors and boundaries
    clear_prog();
    prog[0] = 8'hC4; prog[4] = 8'hC8; prog[5] = 8'hCF; prog[8] = 8'hCC;
    load_prog();
    run = 1'b1;
    wait_exec(4'h0);
    rtn_flag = 1'b1; step(1); rtn_flag = 1'b0;
    check("underflow_pc", {4'd0, pc}, 8'h00);
    check("underflow_err", {7'd0, stack_err}, 8'h01);
    wait_exec(4'h0);
    flagf_flag = 1'b1; step(1); flagf_flag = 1'b0;
    run = 1'b0; step(1);
    check("halt_clears_err", {7'd0, stack_err}, 8'h00);
    run = 1'b1;
    wait_exec(4'h0);
    jmp_flag = 1'b1; step(1); jmp_flag = 1'b0;
    wait_exec(4'h4);
    jmp_flag = 1'b1; step(1); jmp_flag = 1'b0;
    check("nest2_err", {7'd0, stack_err}, 8'h00);
    wait_exec(4'h8);
    jmp_flag = 1'b1; step(1); jmp_flag = 1'b0;
    check("nest3_pc", {4'd0, pc}, 8'h0C);
    check("overflow_err", {7'd0, stack_err}, 8'h01);
    wait_exec(4'hC);
    rtn_flag = 1'b1; step(1); rtn_flag = 1'b0;
    check("ret3_pc", {4'd0, pc}, 8'h09);
    wait_exec(4'h9);
    rtn_flag = 1'b1; step(1); rtn_flag = 1'b0;
    check("ret2_pc", {4'd0, pc}, 8'h05);
    wait_exec(4'h5);
    jmp_flag = 1'b1; step(1); jmp_flag = 1'b0;
    check("jmp15_pc", {4'd0, pc}, 8'h0F);
    wait_exec(4'hF);
    step(1);
    check("wrap_pc", {4'd0, pc}, 8'h00);
    wait_exec(4'h0);
    jmp_flag = 1'b1; rtn_flag = 1'b1; step(1);
    jmp_flag = 1'b0; rtn_flag = 1'b0;
    check("jmp_beats_rtn", {4'd0, pc}, 8'h04);
    prog_we = 1'b1; prog_addr = 4'h4; prog_data = 8'hAA;
    step(2);
    prog_we = 1'b0;
    wait_exec(4'h6);
    flagf_flag = 1'b1; step(1); flagf_flag = 1'b0;
    run = 1'b0; step(1);
    run = 1'b1;
    wait_exec(4'h0);
    jmp_flag = 1'b1; step(1); jmp_flag = 1'b0;
    check("we_ignored_instr", {4'd0, instr}, 8'h0C);
    check("we_ignored_operand", {4'd0, operand}, 8'h08);

    // asynchronous reset in the middle of FETCH
    #2 rst_n = 1'b0;
    #1;
    check("arst_instr", {4'd0, instr}, 8'h00);
    check("arst_operand", {4'd0, operand}, 8'h00);
    check("arst_valid", {7'd0, instr_valid}, 8'h00);
    check("arst_phase", {7'd0, phase}, 8'h00);
    check("arst_pc", {4'd0, pc}, 8'h00);
    check("arst_halted", {7'd0, halted}, 8'h00);
    check("arst_stack_err", {7'd0, stack_err}, 8'h00);
    run = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(2);
    check("post_rst_state", {6'd0, dbg_state}, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ue14500_sequencer.md
# ue14500_sequencer

Program sequencer that feeds the UE14500 1-bit CPU core, the instruction-source end of the core's instruction/flag interface. It holds a small writable program store and a program counter, and presents one 4-bit opcode plus a 4-bit operand for two clocks per instruction (fetch phase, then execute phase). It reacts to the core's JMP/RTN/NOPF flags by redirecting, returning or halting. It sits between the tile I/O (program load, run control) and the CPU core.

## Interface
- ADDR_W, 4, program-store address width (depth 2^ADDR_W words of 8 bits: [7:4] opcode, [3:0] operand)
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous and active-low
- run  in  1  level; high lets the sequencer step the program
- prog_we  in  1  program-store write strobe (honoured only in IDLE or HALT)
- prog_addr  in  ADDR_W  write address
- prog_data  in  8  write data
- instr  out  4  opcode to the CPU core
- operand  out  4  operand/jump target for the current instruction
- instr_valid  out  1  high in FETCH and EXEC
- phase  out  1  0 = FETCH, 1 = EXEC
- jmp_flag  in  1  CPU JMP flag, sampled in EXEC
- rtn_flag  in  1  CPU RTN flag, sampled in EXEC
- flagf_flag  in  1  CPU NOPF flag, sampled in EXEC
- pc  out  ADDR_W  address of the current or next instruction
- halted  out  1  high in HALT
- stack_err  out  1  sticky; set on return-stack underflow or overflow

## Operation
- States: IDLE, FETCH, EXEC, HALT. Reset enters IDLE.
- IDLE: `instr_valid`=0, `instr`=0, `operand`=0. If `run`=1, load `instr`/`operand` from mem[pc] and go to FETCH.
- FETCH: lasts exactly 1 cycle, then go to EXEC. `instr`/`operand` are held.
- EXEC: lasts exactly 1 cycle. The flags are sampled on the closing edge, with priority flagf > jmp > rtn:
  - flagf: go to HALT. pc = pc+1.
  - jmp: push pc+1 onto the return stack. pc = operand[ADDR_W-1:0].
  - rtn: pop the return stack into pc.
  - none: pc = pc+1.
  - Then, if `run`=1, fetch mem[new pc] and go to FETCH. Otherwise go to IDLE.
- `run` is examined only at the end of EXEC and in IDLE. Dropping `run` mid-instruction completes the instruction.
- Return stack: 2 entries, with a depth counter 0..2.
  - Push at depth 2 discards the oldest entry and sets `stack_err`.
  - Pop at depth 0 loads pc = 0 and sets `stack_err`.
- pc arithmetic wraps modulo 2^ADDR_W (last address + 1 = 0).
- HALT: `halted`=1, `instr_valid`=0, `instr`=0. Stay in HALT while `run`=1. On `run`=0, go to IDLE with pc=0, stack depth=0, `stack_err` cleared.
- `prog_we` in FETCH/EXEC is ignored. In IDLE/HALT it writes mem[prog_addr] on the clock edge. A write to the address being fetched in the same cycle supplies the old word.
- Program store is not reset (contents undefined after power-up). All control state is reset.

## Timing
- Reset values: `instr`=0, `operand`=0, `instr_valid`=0, `phase`=0, `pc`=0, `halted`=0, `stack_err`=0, stack depth 0. Reset asserted mid-instruction aborts immediately to IDLE.
- Outputs are registered. The instruction appears 1 cycle after the edge that sees `run`=1 in IDLE.
- Throughput: 1 instruction per 2 cycles, with no bubble between consecutive instructions while `run`=1.
- CPU flags must be valid during the EXEC cycle. A flag asserted in FETCH only is ignored.
- Redirect (jmp/rtn) takes effect on the very next FETCH: 0 extra cycles.

## Test plan
- Linear program: load mem[0..2] = {0x41 ONE, 0x80 STO, 0x00}, pulse `run` high, with no flags.
  - Expected: `instr` sequence 4,4,8,8,0,0; `phase` 0,1 alternating; `pc` 0→1→2→3.
- Jump/return: mem[1]=0xC6 (JMP to 6); assert `jmp_flag` in EXEC of pc=1; later assert `rtn_flag` in EXEC of pc=7.
  - Expected: next fetch at pc=6, then 7, then 2; `stack_err`=0.
- Halt and restart: assert `flagf_flag` in EXEC at pc=3.
  - Expected: `halted`=1 and `instr_valid`=0 next cycle, held while `run`=1; after `run`=0, IDLE with pc=0.
  - Then `run`=1: fetch of mem[0].
- Stack errors:
  - rtn at depth 0: pc=0 and `stack_err`=1.
  - Three nested jumps: third sets `stack_err`; returns go to the 3rd and 2nd return addresses.
- Boundaries:
  - pc=15 with no flag: next pc=0.
  - jmp+rtn in the same EXEC: jmp wins.
  - `prog_we` during EXEC: memory unchanged (read back after halt).
  - rst_n low mid-FETCH: all outputs at reset values asynchronously.
